barrett_mu_gen: RTL and testbench

Sequential precompute engine that produces the Barrett constant mu = floor(2^SHIFT / m) for a modulus m. It sits upstream of `barrett_pipelined` and supplies the `m_i`/`mu_i` pair that the reducer consumes. The reducer's inputs therefore come from hardware, not testbench constants. The constant is computed by bit-serial restoring division with a start/valid handshake, one quotient bit per cycle.

---
 rtl/barrett_mu_gen.sv | 127 ++++++++++++
 tb/tb_barrett_mu_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/barrett_mu_gen.sv
// Barrett constant generator: mu = floor(2^SHIFT / m) by bit-serial
// restoring division, one quotient bit per clock, start/valid handshake.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   start_i  request, sampled in IDLE or DONE
//   m_i      modulus, latched on the accepting edge
//   busy_o   high while dividing
//   valid_o  one-cycle result strobe
//   mu_o     floor(2^SHIFT / m)
//   rem_o    2^SHIFT mod m
//   m_o      modulus matching mu_o
//   err_o    modulus was below 2; mu_o/rem_o forced to 0
module barrett_mu_gen #(
    parameter int WIDTH = 64,
    parameter int SHIFT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] m_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [SHIFT-1:0] mu_o,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] m_o,
    output logic             err_o
);

    localparam int CW = $clog2(SHIFT + 1);
    localparam int RW = WIDTH + 1;
    localparam int TW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] m_q;
    logic [RW-1:0]    r_q;
    logic [SHIFT-1:0] q_q;
    logic [CW-1:0]    cnt_q;

    logic             dbit;
    logic [TW-1:0]    t;
    logic [TW-1:0]    m_ext;
    logic             ge;
    logic [TW-1:0]    r_nx;
    logic [SHIFT-1:0] q_nx;

    // Dividend is 2^SHIFT: a single 1 followed by SHIFT zeros.
    // The quotient MSB is always 0 for m >= 2, so shifting it out of
    // the SHIFT-bit register loses nothing.
    always_comb begin
        dbit  = (cnt_q == CW'(SHIFT));
        t     = {r_q, dbit};
        m_ext = {2'b00, m_q};
        ge    = (t >= m_ext);
        r_nx  = ge ? (t - m_ext) : t;
        q_nx  = (q_q << 1) | SHIFT'(ge);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            m_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            mu_o    <= '0;
            rem_o   <= '0;
            m_o     <= '0;
            err_o   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                    if (start_i) begin
                        m_q <= m_i;
                        if (m_i < WIDTH'(2)) begin
                            // Degenerate modulus: report at once
                            mu_o    <= '0;
                            rem_o   <= '0;
                            m_o     <= m_i;
                            err_o   <= 1'b1;
                            valid_o <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            r_q     <= '0;
                            q_q     <= '0;
                            cnt_q   <= CW'(SHIFT);
                            busy_o  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q   <= RW'(r_nx);
                    q_q   <= q_nx;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        mu_o    <= q_nx;
                        rem_o   <= WIDTH'(r_nx);
                        m_o     <= m_q;
                        err_o   <= 1'b0;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_o  <= 1'b0;
                    valid_o <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_mu_gen.sv
// Self-checking bench for barrett_mu_gen: directed cases plus random
// moduli checked against 128-bit arithmetic and a Barrett reduction.
module tb_barrett_mu_gen;

    localparam int W = 64;
    localparam int S = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] m_in = '0;
    logic         busy;
    logic         valid;
    logic [S-1:0] mu;
    logic [W-1:0] rem;
    logic [W-1:0] m_out;
    logic         err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    barrett_mu_gen #(.WIDTH(W), .SHIFT(S)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .m_i     (m_in),
        .busy_o  (busy),
        .valid_o (valid),
        .mu_o    (mu),
        .rem_o   (rem),
        .m_o     (m_out),
        .err_o   (err)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_mu(input logic [63:0] m);
        logic [127:0] p;
        p = 128'd1 << 64;
        return p / {64'd0, m};
    endfunction

    function automatic logic [127:0] ref_rem(input logic [63:0] m);
        logic [127:0] p;
        p = 128'd1 << 64;
        return p % {64'd0, m};
    endfunction

    // Pulse start for one cycle, then wait for valid.
    // lat = clock edges after the accepting edge until valid is seen.
    task automatic do_req(input logic [W-1:0] m, output int lat,
                          output int bn);
        start = 1'b1;
        m_in  = m;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bn  = 0;
        while (valid !== 1'b1 && lat < 300) begin
            if (busy) bn++;
            @(negedge clk);
            lat++;
        end
        if (valid !== 1'b1) chk("valid_timeout", {127'd0, valid}, 128'd1);
    endtask

    int           lat;
    int           bn;
    int           seen;
    logic [63:0]  rm;
    logic [63:0]  x;
    logic [127:0] prod;
    logic [127:0] q;
    logic [127:0] r;

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_valid", {127'd0, valid}, 128'd0);
        chk("rst_mu", {64'd0, mu}, 128'd0);
        chk("rst_rem", {64'd0, rem}, 128'd0);
        chk("rst_m", {64'd0, m_out}, 128'd0);
        chk("rst_err", {127'd0, err}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // m = 3
        do_req(64'd3, lat, bn);
        chk("m3_lat", lat, S + 1);
        chk("m3_busy_cycles", bn, S + 1);
        chk("m3_mu", {64'd0, mu}, 128'h5555_5555_5555_5555);
        chk("m3_rem", {64'd0, rem}, 128'd1);
        chk("m3_m", {64'd0, m_out}, 128'd3);
        chk("m3_err", {127'd0, err}, 128'd0);
        @(negedge clk);
        chk("m3_valid_pulse", {127'd0, valid}, 128'd0);

        // Back-to-back: m = 2, then all-ones issued in the DONE cycle
        do_req(64'd2, lat, bn);
        chk("m2_mu", {64'd0, mu}, 128'h8000_0000_0000_0000);
        chk("m2_rem", {64'd0, rem}, 128'd0);
        do_req(64'hFFFF_FFFF_FFFF_FFFF, lat, bn);
        chk("b2b_gap", lat + 1, S + 2);
        chk("mff_mu", {64'd0, mu}, 128'd1);
        chk("mff_rem", {64'd0, rem}, 128'd1);

        // m = 5 with start held and m_i scrambled during CALC
        @(negedge clk);
        start = 1'b1;
        m_in  = 64'd5;
        @(negedge clk);
        lat = 0;
        while (valid !== 1'b1 && lat < 300) begin
            m_in = {$urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        chk("m5_lat", lat, S + 1);
        chk("m5_mu", {64'd0, mu}, 128'h3333_3333_3333_3333);
        chk("m5_rem", {64'd0, rem}, 128'd1);
        m_in = 64'd7;
        @(negedge clk);
        start = 1'b0;
        chk("m7_started_busy", {127'd0, busy}, 128'd1);
        chk("m7_started_novalid", {127'd0, valid}, 128'd0);
        lat = 0;
        while (valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("m7_mu", {64'd0, mu}, ref_mu(64'd7));
        chk("m7_rem", {64'd0, rem}, ref_rem(64'd7));
        @(negedge clk);

        // Degenerate moduli
        do_req(64'd0, lat, bn);
        chk("m0_lat", lat, 0);
        chk("m0_err", {127'd0, err}, 128'd1);
        chk("m0_mu", {64'd0, mu}, 128'd0);
        chk("m0_rem", {64'd0, rem}, 128'd0);
        chk("m0_nobusy", bn, 0);
        @(negedge clk);
        chk("m0_valid_pulse", {127'd0, valid}, 128'd0);
        do_req(64'd1, lat, bn);
        chk("m1_lat", lat, 0);
        chk("m1_err", {127'd0, err}, 128'd1);
        chk("m1_m", {64'd0, m_out}, 128'd1);
        chk("m1_mu", {64'd0, mu}, 128'd0);
        @(negedge clk);

        // Leave a non-zero result behind, then abort with reset mid-CALC
        do_req(64'd7, lat, bn);
        chk("m7b_mu", {64'd0, mu}, ref_mu(64'd7));
        @(negedge clk);
        start = 1'b1;
        m_in  = 64'h1_0000_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        chk("abort_busy_before", {127'd0, busy}, 128'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_valid", {127'd0, valid}, 128'd0);
        chk("abort_mu", {64'd0, mu}, 128'd0);
        chk("abort_rem", {64'd0, rem}, 128'd0);
        chk("abort_m", {64'd0, m_out}, 128'd0);
        chk("abort_err", {127'd0, err}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (valid === 1'b1 || busy === 1'b1) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
        do_req(64'h1_0000_0000, lat, bn);
        chk("restart_mu", {64'd0, mu}, 128'h1_0000_0000);
        chk("restart_rem", {64'd0, rem}, 128'd0);
        @(negedge clk);

        // Random moduli
        for (int i = 0; i < 100; i++) begin
            rm = {$urandom, $urandom};
            if (rm < 64'd2) rm = 64'd2;
            do_req(rm, lat, bn);
            chk("rnd_mu", {64'd0, mu}, ref_mu(rm));
            prod = {64'd0, mu} * {64'd0, m_out} + {64'd0, rem};
            chk("rnd_identity", prod, 128'd1 << 64);
            chk("rnd_rem_lt_m", {127'd0, (rem < m_out)}, 128'd1);
            chk("rnd_m", {64'd0, m_out}, {64'd0, rm});
            if (i < 10) begin
                // Barrett reduction of a random x using the produced pair
                x = {$urandom, $urandom};
                q = ({64'd0, x} * {64'd0, mu}) >> 64;
                r = {64'd0, x} - q * {64'd0, m_out};
                for (int k = 0; k < 3; k++)
                    if (r >= {64'd0, m_out}) r = r - {64'd0, m_out};
                chk("barrett_reduce", r, {64'd0, x} % {64'd0, rm});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
